shift_issue_ctrl: RTL
=====================

Name: shift_issue_ctrl

Overview:
Initiator side of the multi-cycle shift unit's start/done protocol inside ALU2.
- Accepts decoded shift micro-ops (SLL/SRL/SRA) from the ALU2 dispatcher over a valid/ready handshake.
- Drives the shift unit's start/operand/mode inputs, waits for its done level, and captures the result.
- Returns the result with its destination register tag over a valid/ready handshake toward writeback.
- Handles one operation in flight at a time.

Parameters:
XLEN, core_config_pkg::XLEN (32), datapath width
SHAMT_W, $clog2(XLEN) (5), shift amount width
RD_W, 5, destination register tag width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_valid  in  1  upstream op valid
i_ready  out  1  upstream ready
i_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 reserved (executes as SLL)
i_rs1  in  XLEN  value to shift
i_rs2  in  XLEN  amount source; only bits [SHAMT_W-1:0] used
i_rd  in  RD_W  destination tag
o_valid  out  1  result valid
o_ready  in  1  downstream ready
o_result  out  XLEN  shifted value
o_rd  out  RD_W  tag of the result
sh_start  out  1  start pulse to shift unit
sh_data_in  out  XLEN  operand to shift unit
sh_shift_amount  out  SHAMT_W  amount to shift unit
sh_shift_left  out  1  1 = left
sh_arithmetic  out  1  1 = arithmetic right
sh_data_out  in  XLEN  shift unit result
sh_done  in  1  shift unit done level

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0 and state IDLE. This includes i_ready, o_valid, o_result, o_rd and all sh_* outputs.
- FSM states: IDLE, LAUNCH, WAIT, RESP. All outputs are registered.
- IDLE:
  - i_ready=1.
  - On i_valid&&i_ready, latch rs1, rs2[SHAMT_W-1:0], rd and decoded mode:
    - SLL/11: left=1, arith=0
    - SRL: left=0, arith=0
    - SRA: left=0, arith=1
  - Go to LAUNCH.
- LAUNCH:
  - i_ready=0. sh_start=1 for exactly this one cycle.
  - sh_data_in, sh_shift_amount, sh_shift_left and sh_arithmetic hold the latched values from this cycle until the op leaves WAIT.
  - Next state: WAIT.
- WAIT:
  - sh_start=0.
  - The shift unit holds done high in idle and clears it on the edge that accepts start, so done is already low when WAIT is entered.
  - When sh_done=1: capture sh_data_out into o_result, latched rd into o_rd, and go to RESP.
  - sh_done is ignored in every other state.
- RESP:
  - o_valid=1. o_result and o_rd are stable until o_ready.
  - On o_valid&&o_ready, go to IDLE, where o_valid=0 and i_ready=1 on the next cycle. No back-to-back accept from RESP.
- Latency (MAX_SHIFT_PER_CYCLE=M, amount n, k=ceil(n/M)+1):
  - Accept in cycle A. sh_start is high in A+1. sh_done rises at A+2+k. o_valid rises at A+3+k.
  - n=0 gives o_valid at A+4.
- Backpressure: o_ready low holds RESP indefinitely. No further op is accepted.
- Mid-operation reset: returns to IDLE immediately with outputs cleared. The in-flight op is dropped and no result is produced. The shift unit shares rst_n, so no stale done survives.
- i_valid while not in IDLE: ignored; inputs are not sampled.

Optional Feature:
SHIFT_ZERO_BYPASS_EN
- Defined:
  - An accepted op with rs2[SHAMT_W-1:0]==0 goes IDLE→RESP directly.
  - o_result=rs1, o_valid at A+1.
  - sh_start is never asserted for that op.
- Undefined: zero-amount ops take the normal path and latency (o_valid at A+4).

Test Plan:
- Reset then idle:
  - During reset: all outputs 0.
  - After release: i_ready=1, o_valid=0, sh_start=0.
- SLL, rs1=0x0000_0001, rs2=4, rd=7, M=3 -> one sh_start pulse with left=1, arith=0, amount=4. o_valid at A+6 with o_result=0x0000_0010, o_rd=7.
- SRA, rs1=0x8000_0000, rs2=31, M=3 -> o_valid at A+15 with o_result=0xFFFF_FFFF. SRL with the same operands gives 0x0000_0001.
- SRL with rs2=0xFFFF_FFE3 (amount 3) and op 11 with rs2=1 -> upper rs2 bits ignored (SRL shifts by 3). The reserved op behaves as SLL by 1.
- Backpressure: o_ready=0 for 10 cycles in RESP while i_valid=1 -> o_result/o_rd stable, i_ready=0, no sh_start. On o_ready=1 the handshake completes and i_ready=1 the next cycle.
- Reset asserted in WAIT -> outputs 0 asynchronously. After release, a new op completes correctly with no spurious o_valid. With SHIFT_ZERO_BYPASS_EN, rs2=0 gives o_valid at A+1, o_result=rs1 and no sh_start.

Source files
------------

// File: rtl/shift_issue_ctrl_if.sv
// rtl/shift_issue_ctrl_if.sv - dispatcher, writeback and shift-unit signals of the shift issue controller
// master: the issue controller itself; slave: the surrounding ALU2 logic and shift unit.
interface shift_issue_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int RD_W    = 5,
  parameter int SHAMT_W = $clog2(XLEN)
);
  // dispatcher side
  logic               i_valid;
  logic               i_ready;
  logic [1:0]         i_op;
  logic [XLEN-1:0]    i_rs1;
  logic [XLEN-1:0]    i_rs2;
  logic [RD_W-1:0]    i_rd;
  // writeback side
  logic               o_valid;
  logic               o_ready;
  logic [XLEN-1:0]    o_result;
  logic [RD_W-1:0]    o_rd;
  // shift unit side
  logic               sh_start;
  logic [XLEN-1:0]    sh_data_in;
  logic [SHAMT_W-1:0] sh_shift_amount;
  logic               sh_shift_left;
  logic               sh_arithmetic;
  logic [XLEN-1:0]    sh_data_out;
  logic               sh_done;

  modport master (
    input  i_valid, i_op, i_rs1, i_rs2, i_rd,
    output i_ready,
    output o_valid, o_result, o_rd,
    input  o_ready,
    output sh_start, sh_data_in, sh_shift_amount, sh_shift_left, sh_arithmetic,
    input  sh_data_out, sh_done
  );

  modport slave (
    output i_valid, i_op, i_rs1, i_rs2, i_rd,
    input  i_ready,
    input  o_valid, o_result, o_rd,
    output o_ready,
    input  sh_start, sh_data_in, sh_shift_amount, sh_shift_left, sh_arithmetic,
    output sh_data_out, sh_done
  );
endinterface

// File: rtl/shift_issue_ctrl.sv
// rtl/shift_issue_ctrl.sv - start/done initiator for the ALU2 multi-cycle shift unit, one op in flight
// Optional: define SHIFT_ZERO_BYPASS_EN to answer zero-amount shifts directly from IDLE.
module shift_issue_ctrl #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN),
  parameter int RD_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_issue_ctrl_if.master    bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e             state_q;
  logic               i_ready_q;
  logic               o_valid_q;
  logic [XLEN-1:0]    o_result_q;
  logic [RD_W-1:0]    o_rd_q;
  logic               sh_start_q;
  logic [XLEN-1:0]    data_q;
  logic [SHAMT_W-1:0] amt_q;
  logic               left_q;
  logic               arith_q;
  logic [RD_W-1:0]    rd_q;

  // Only the low SHAMT_W bits of rs2 carry the amount.
  logic unused_rs2_hi;
  assign unused_rs2_hi = ^bus.i_rs2[XLEN-1:SHAMT_W];

  logic accept;
  logic dec_left;
  logic dec_arith;
  assign accept    = (state_q == S_IDLE) && bus.i_valid && i_ready_q;
  // Reserved op 2'b11 falls through to SLL.
  assign dec_left  = (bus.i_op != 2'b01) && (bus.i_op != 2'b10);
  assign dec_arith = (bus.i_op == 2'b10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      i_ready_q  <= 1'b0;
      o_valid_q  <= 1'b0;
      o_result_q <= '0;
      o_rd_q     <= '0;
      sh_start_q <= 1'b0;
      data_q     <= '0;
      amt_q      <= '0;
      left_q     <= 1'b0;
      arith_q    <= 1'b0;
      rd_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          i_ready_q <= 1'b1;
          if (accept) begin
            i_ready_q <= 1'b0;
            data_q    <= bus.i_rs1;
            amt_q     <= bus.i_rs2[SHAMT_W-1:0];
            rd_q      <= bus.i_rd;
            left_q    <= dec_left;
            arith_q   <= dec_arith;
`ifdef SHIFT_ZERO_BYPASS_EN
            if (bus.i_rs2[SHAMT_W-1:0] == '0) begin
              o_result_q <= bus.i_rs1;
              o_rd_q     <= bus.i_rd;
              o_valid_q  <= 1'b1;
              state_q    <= S_RESP;
            end else begin
              sh_start_q <= 1'b1;
              state_q    <= S_LAUNCH;
            end
`else
            sh_start_q <= 1'b1;
            state_q    <= S_LAUNCH;
`endif
          end
        end
        S_LAUNCH: begin
          sh_start_q <= 1'b0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          // The unit drops done on the start edge, so a high done here is this op's result.
          if (bus.sh_done) begin
            o_result_q <= bus.sh_data_out;
            o_rd_q     <= rd_q;
            o_valid_q  <= 1'b1;
            state_q    <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.o_ready) begin
            o_valid_q <= 1'b0;
            i_ready_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.i_ready         = i_ready_q;
  assign bus.o_valid         = o_valid_q;
  assign bus.o_result        = o_result_q;
  assign bus.o_rd            = o_rd_q;
  assign bus.sh_start        = sh_start_q;
  assign bus.sh_data_in      = data_q;
  assign bus.sh_shift_amount = amt_q;
  assign bus.sh_shift_left   = left_q;
  assign bus.sh_arithmetic   = arith_q;

endmodule
